// File: rtl/spi_master_mcs_if.sv
// spi_master_mcs_if
//   Client-side word stream bundle for spi_master_mcs.
//   Signal names match the original flat port names so the client-side
//   wiring reads the same as before.
//   Signals:
//     i_TX_BYTE   word to transmit
//     i_TX_DE     TX valid; accepted when i_TX_DE & o_TX_READY
//     o_TX_READY  master can accept a word this cycle
//     i_CS_SEL    target chip-select index, latched at the first accept of a frame
//     i_HOLD_CS   latched per word; 1 keeps CS asserted after this word
//     o_RX_BYTE   last received word
//     o_RX_DE     one-cycle pulse, o_RX_BYTE valid
//   Modports:
//     master  used by spi_master_mcs
//     slave   used by the word-stream client
interface spi_master_mcs_if #(
    parameter int DWIDTH = 8,
    parameter int NUM_CS = 4
);
    localparam int SELW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic [DWIDTH-1:0] i_TX_BYTE;
    logic              i_TX_DE;
    logic              o_TX_READY;
    logic [SELW-1:0]   i_CS_SEL;
    logic              i_HOLD_CS;
    logic [DWIDTH-1:0] o_RX_BYTE;
    logic              o_RX_DE;

    modport master (
        input  i_TX_BYTE, i_TX_DE, i_CS_SEL, i_HOLD_CS,
        output o_TX_READY, o_RX_BYTE, o_RX_DE
    );

    modport slave (
        output i_TX_BYTE, i_TX_DE, i_CS_SEL, i_HOLD_CS,
        input  o_TX_READY, o_RX_BYTE, o_RX_DE
    );
endinterface

// File: rtl/spi_master_mcs.sv
// spi_master_mcs
//   SPI master for all four CPOL/CPHA modes with a programmable SCLK
//   divider, NUM_CS one-hot active-low chip selects and burst transfers
//   that keep CS asserted between words. All outputs are registered.
//   Ports:
//     i_clk          system clock
//     rst_n          asynchronous active-low reset
//     io_bus         word-stream handshake (spi_master_mcs_if.master)
//     clockPolarity  CPOL, sampled in IDLE only
//     clockPhase     CPHA, sampled in IDLE only
//     i_LSB_FIRST    only with SPI_MASTER_MCS_LSB_FIRST_EN; LSB-first shifting
//     o_spi_clk      SCLK
//     i_spi_miso     serial in (already synchronised)
//     o_spi_mosi     serial out
//     o_spi_cs       active-low chip selects, at most one low
//   Build option: define SPI_MASTER_MCS_LSB_FIRST_EN to add i_LSB_FIRST.
module spi_master_mcs #(
    parameter int DWIDTH  = 8,
    parameter int NUM_CS  = 4,
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic              i_clk,
    input  logic              rst_n,
    spi_master_mcs_if.master  io_bus,
    input  logic              clockPolarity,
    input  logic              clockPhase,
`ifdef SPI_MASTER_MCS_LSB_FIRST_EN
    input  logic              i_LSB_FIRST,
`endif
    output logic              o_spi_clk,
    input  logic              i_spi_miso,
    output logic              o_spi_mosi,
    output logic [NUM_CS-1:0] o_spi_cs
);
    localparam int SELW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int MAXC = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int EW   = $clog2(2 * DWIDTH + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, BURST_WAIT, GAP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [EW-1:0]     r_edge;
    logic              r_cpol;
    logic              r_cpha;
    logic              r_lsb;
    logic              r_hold;
    logic [DWIDTH-1:0] r_tx;
    logic [DWIDTH-1:0] r_rx;

    logic              w_lsb_in;
    logic              w_accept;
    logic              w_setup_done;
    logic              w_tick;
    logic              w_done;
    logic              w_gap_done;
    logic              w_lead;
    logic              w_sample;
    logic              w_shift;
    logic              w_ld_cpha;
    logic              w_ld_lsb;
    logic              w_ld_bit;
    logic [DWIDTH-1:0] w_ld_rest;
    logic              w_tx_bit;
    logic [DWIDTH-1:0] w_tx_rest;
    logic [DWIDTH-1:0] w_rx_next;
    logic [NUM_CS-1:0] w_cs_dec;

`ifdef SPI_MASTER_MCS_LSB_FIRST_EN
    assign w_lsb_in = i_LSB_FIRST;
`else
    assign w_lsb_in = 1'b0;
`endif

    // o_TX_READY is only ever high in IDLE or BURST_WAIT, so it doubles
    // as the state qualifier for an accept.
    assign w_accept     = io_bus.i_TX_DE & io_bus.o_TX_READY;
    assign w_setup_done = (r_cnt == CW'(CLK_DIV - 1));
    assign w_tick       = (r_cnt == CW'(CLK_DIV - 1)) && (r_edge != EW'(2 * DWIDTH));
    assign w_done       = (r_edge == EW'(2 * DWIDTH)) && (r_cnt == CW'(CLK_DIV));
    assign w_gap_done   = (r_cnt == CW'(CS_GAP - 1));

    // Edge index is even for leading edges (first edge of each SCLK period).
    assign w_lead   = ~r_edge[0];
    assign w_sample = r_cpha ? ~w_lead : w_lead;
    // CPHA=0 already put the first bit out at accept, so the final trailing
    // edge has nothing left to shift.
    assign w_shift  = r_cpha ? w_lead : (~w_lead && (r_edge != EW'(2 * DWIDTH - 1)));

    // A burst word reuses the mode latched at the start of the frame.
    assign w_ld_cpha = (r_state == IDLE) ? clockPhase : r_cpha;
    assign w_ld_lsb  = (r_state == IDLE) ? w_lsb_in   : r_lsb;
    assign w_ld_bit  = w_ld_lsb ? io_bus.i_TX_BYTE[0] : io_bus.i_TX_BYTE[DWIDTH-1];
    assign w_ld_rest = w_ld_lsb ? (io_bus.i_TX_BYTE >> 1) : (io_bus.i_TX_BYTE << 1);
    assign w_tx_bit  = r_lsb ? r_tx[0] : r_tx[DWIDTH-1];
    assign w_tx_rest = r_lsb ? (r_tx >> 1) : (r_tx << 1);
    // LSB-first fills from the top so the word ends up in natural order.
    assign w_rx_next = r_lsb ? {i_spi_miso, r_rx[DWIDTH-1:1]}
                             : {r_rx[DWIDTH-2:0], i_spi_miso};

    // Out-of-range selects match nothing and leave every CS high.
    always_comb begin
        w_cs_dec = '1;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (io_bus.i_CS_SEL == SELW'(i)) begin
                w_cs_dec[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       if (w_accept)     w_next = SETUP;
            SETUP:      if (w_setup_done) w_next = SHIFT;
            SHIFT:      if (w_done)       w_next = r_hold ? BURST_WAIT : GAP;
            BURST_WAIT: if (w_accept)     w_next = SETUP;
            GAP:        if (w_gap_done)   w_next = IDLE;
            default:                      w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt             <= '0;
            r_edge            <= '0;
            r_cpol            <= 1'b0;
            r_cpha            <= 1'b0;
            r_lsb             <= 1'b0;
            r_hold            <= 1'b0;
            r_tx              <= '0;
            r_rx              <= '0;
            o_spi_clk         <= 1'b0;
            o_spi_mosi        <= 1'b0;
            o_spi_cs          <= '1;
            io_bus.o_RX_BYTE  <= '0;
            io_bus.o_RX_DE    <= 1'b0;
            io_bus.o_TX_READY <= 1'b0;
        end else begin
            io_bus.o_RX_DE    <= 1'b0;
            io_bus.o_TX_READY <= (w_next == IDLE) || (w_next == BURST_WAIT);

            case (r_state)
                IDLE: begin
                    r_cpol    <= clockPolarity;
                    r_cpha    <= clockPhase;
                    r_lsb     <= w_lsb_in;
                    o_spi_clk <= clockPolarity;
                    if (w_accept) begin
                        o_spi_cs <= w_cs_dec;
                    end
                end
                SETUP: begin
                    r_cnt <= w_setup_done ? '0 : r_cnt + CW'(1);
                end
                SHIFT: begin
                    if (w_tick) begin
                        o_spi_clk <= ~o_spi_clk;
                        r_edge    <= r_edge + EW'(1);
                        r_cnt     <= '0;
                        if (w_sample) begin
                            r_rx <= w_rx_next;
                        end
                        if (w_shift) begin
                            o_spi_mosi <= w_tx_bit;
                            r_tx       <= w_tx_rest;
                        end
                    end else if (w_done) begin
                        io_bus.o_RX_DE   <= 1'b1;
                        io_bus.o_RX_BYTE <= r_rx;
                        r_cnt            <= '0;
                        if (!r_hold) begin
                            o_spi_cs <= '1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                BURST_WAIT: begin
                    o_spi_clk <= r_cpol;
                end
                GAP: begin
                    o_spi_cs  <= '1;
                    o_spi_clk <= r_cpol;
                    r_cnt     <= w_gap_done ? '0 : r_cnt + CW'(1);
                end
                default: begin
                    o_spi_cs <= '1;
                end
            endcase

            // Word load shared by the first accept of a frame and burst accepts.
            if (w_accept) begin
                r_hold <= io_bus.i_HOLD_CS;
                r_cnt  <= '0;
                r_edge <= '0;
                r_rx   <= '0;
                if (!w_ld_cpha) begin
                    o_spi_mosi <= w_ld_bit;
                    r_tx       <= w_ld_rest;
                end else begin
                    r_tx <= io_bus.i_TX_BYTE;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_master_mcs.sv
module tb_spi_master_mcs;
    logic       i_clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cpol_in = 1'b0;
    logic       cpha_in = 1'b0;
    logic       lsb_in = 1'b0;
    logic       o_spi_clk;
    logic       o_spi_mosi;
    logic [2:0] o_spi_cs;
    logic       tb_miso;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int n_rxde   = 0;

    // Slave model state
    logic [7:0] s_echo = 8'h00;
    logic [7:0] s_mosi = 8'h00;
    bit         s_cpol = 1'b0;
    bit         s_cpha = 1'b0;
    bit         s_lsb  = 1'b0;
    bit         s_active = 1'b0;
    int         s_shift = 0;
    int         s_edges = 0;
    int         s_b;

    spi_master_mcs_if #(.DWIDTH(8), .NUM_CS(3)) bus_if ();

    spi_master_mcs #(.DWIDTH(8), .NUM_CS(3), .CLK_DIV(2), .CS_GAP(2)) dut (
        .i_clk         (i_clk),
        .rst_n         (rst_n),
        .io_bus        (bus_if),
        .clockPolarity (cpol_in),
        .clockPhase    (cpha_in),
`ifdef SPI_MASTER_MCS_LSB_FIRST_EN
        .i_LSB_FIRST   (lsb_in),
`endif
        .o_spi_clk     (o_spi_clk),
        .i_spi_miso    (tb_miso),
        .o_spi_mosi    (o_spi_mosi),
        .o_spi_cs      (o_spi_cs)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (bus_if.i_TX_DE && bus_if.o_TX_READY) n_acc++;
        if (bus_if.o_RX_DE) n_rxde++;
    end

    always_comb begin
        s_b = s_cpha ? s_shift - 1 : s_shift;
        if (s_b < 0) s_b = 0;
        if (s_b > 7) s_b = 7;
        tb_miso = s_lsb ? s_echo[s_b] : s_echo[7 - s_b];
    end

    // Sampling edge: leading for CPHA=0, trailing for CPHA=1.
    always @(o_spi_clk) begin
        if (s_active) begin
            s_edges++;
            if (((o_spi_clk != s_cpol) ? 1'b1 : 1'b0) ^ s_cpha)
                s_mosi = s_lsb ? {o_spi_mosi, s_mosi[7:1]} : {s_mosi[6:0], o_spi_mosi};
            else
                s_shift++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic slave_arm(input bit cpol, input bit cpha, input bit lsb, input logic [7:0] echo);
        s_cpol = cpol; s_cpha = cpha; s_lsb = lsb; s_echo = echo;
        s_shift = 0; s_mosi = 8'h00; s_active = 1'b1;
    endtask

    task automatic set_mode(input bit cpol, input bit cpha);
        cpol_in = cpol; cpha_in = cpha;
        repeat (3) @(posedge i_clk);
        #1;
    endtask

    // Drives one word and waits (bounded) for o_RX_DE; lat stays 0 on timeout.
    task automatic send_word(input logic [7:0] data, input logic [1:0] sel, input logic hold,
                             input logic [2:0] exp_cs, input bit keep_de,
                             output int lat, output logic [7:0] rx, output bit cs_ok, output int edges);
        int e0;
        for (int i = 0; i < 100; i++) begin
            if (bus_if.o_TX_READY === 1'b1) break;
            @(posedge i_clk); #1;
        end
        bus_if.i_TX_BYTE = data; bus_if.i_CS_SEL = sel; bus_if.i_HOLD_CS = hold; bus_if.i_TX_DE = 1'b1;
        @(posedge i_clk);
        e0 = s_edges;
        #1;
        if (!keep_de) bus_if.i_TX_DE = 1'b0;
        lat = 0; rx = 8'h00; cs_ok = (o_spi_cs === exp_cs);
        for (int i = 1; i <= 200; i++) begin
            @(posedge i_clk); #1;
            if (bus_if.o_RX_DE === 1'b1) begin
                lat = i; rx = bus_if.o_RX_BYTE;
                break;
            end
            if (o_spi_cs !== exp_cs) cs_ok = 1'b0;
        end
        edges = s_edges - e0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        n_checks++; if (o_spi_cs !== 3'b111) begin n_fail++; $display("FAIL reset_cs: got %b expected %b", o_spi_cs, 3'b111); end
        n_checks++; if (o_spi_clk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b expected 0", o_spi_clk); end
        n_checks++; if (o_spi_mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b expected 0", o_spi_mosi); end
        n_checks++; if (bus_if.o_RX_BYTE !== 8'h00) begin n_fail++; $display("FAIL reset_rx_byte: got %h expected 00", bus_if.o_RX_BYTE); end
        n_checks++; if (bus_if.o_RX_DE !== 1'b0) begin n_fail++; $display("FAIL reset_rx_de: got %b expected 0", bus_if.o_RX_DE); end
        n_checks++; if (bus_if.o_TX_READY !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", bus_if.o_TX_READY); end
        rst_n = 1'b1;
        @(posedge i_clk); #1;
        n_checks++; if (bus_if.o_TX_READY !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b expected 1", bus_if.o_TX_READY); end
    endtask

    task automatic test_mode0();
        int lat; logic [7:0] rx; bit ok; int ed;
        set_mode(1'b0, 1'b0);
        slave_arm(1'b0, 1'b0, 1'b0, 8'h3C);
        send_word(8'hA5, 2'd0, 1'b0, 3'b110, 1'b0, lat, rx, ok, ed);
        n_checks++; if (lat !== 37) begin n_fail++; $display("FAIL mode0_latency: got %0d expected 37", lat); end
        n_checks++; if (rx !== 8'h3C) begin n_fail++; $display("FAIL mode0_rx: got %h expected 3c", rx); end
        n_checks++; if (s_mosi !== 8'hA5) begin n_fail++; $display("FAIL mode0_mosi: got %h expected a5", s_mosi); end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mode0_cs_low: got %b expected 1", ok); end
        n_checks++; if (ed !== 16) begin n_fail++; $display("FAIL mode0_edges: got %0d expected 16", ed); end
        @(posedge i_clk); #1;
        n_checks++; if (bus_if.o_RX_DE !== 1'b0) begin n_fail++; $display("FAIL mode0_rx_de_pulse: got %b expected 0", bus_if.o_RX_DE); end
        s_active = 1'b0;
    endtask

    task automatic test_modes();
        int lat; logic [7:0] rx; bit ok; int ed;
        for (int m = 1; m < 4; m++) begin
            set_mode(m[1], m[0]);
            n_checks++; if (o_spi_clk !== m[1]) begin n_fail++; $display("FAIL mode%0d_idle_sclk: got %b expected %b", m, o_spi_clk, m[1]); end
            slave_arm(m[1], m[0], 1'b0, 8'h3C);
            send_word(8'hA5, 2'd1, 1'b0, 3'b101, 1'b0, lat, rx, ok, ed);
            n_checks++; if (rx !== 8'h3C) begin n_fail++; $display("FAIL mode%0d_rx: got %h expected 3c", m, rx); end
            n_checks++; if (s_mosi !== 8'hA5) begin n_fail++; $display("FAIL mode%0d_mosi: got %h expected a5", m, s_mosi); end
            n_checks++; if (lat !== 37) begin n_fail++; $display("FAIL mode%0d_latency: got %0d expected 37", m, lat); end
            n_checks++; if (ok !== 1'b1 || ed !== 16) begin n_fail++; $display("FAIL mode%0d_cs_edges: got cs_ok=%b edges=%0d expected 1/16", m, ok, ed); end
            @(posedge i_clk); #1;
            n_checks++; if (o_spi_clk !== m[1]) begin n_fail++; $display("FAIL mode%0d_end_sclk: got %b expected %b", m, o_spi_clk, m[1]); end
            s_active = 1'b0;
        end
        set_mode(1'b0, 1'b0);
    endtask

    task automatic test_burst();
        int lat; logic [7:0] rx; bit ok; int ed; int nrx0;
        set_mode(1'b0, 1'b0);
        nrx0 = n_rxde;
        slave_arm(1'b0, 1'b0, 1'b0, 8'h5C);
        send_word(8'h11, 2'd2, 1'b1, 3'b011, 1'b0, lat, rx, ok, ed);
        n_checks++; if (rx !== 8'h5C || s_mosi !== 8'h11) begin n_fail++; $display("FAIL burst_w1_data: got rx=%h mosi=%h expected 5c/11", rx, s_mosi); end
        n_checks++; if (lat !== 37 || ok !== 1'b1) begin n_fail++; $display("FAIL burst_w1_timing: got lat=%0d cs_ok=%b expected 37/1", lat, ok); end
        n_checks++; if (o_spi_cs !== 3'b011 || bus_if.o_TX_READY !== 1'b1) begin n_fail++; $display("FAIL burst_wait: got cs=%b ready=%b expected 011/1", o_spi_cs, bus_if.o_TX_READY); end
        s_shift = 0; s_mosi = 8'h00; s_echo = 8'hC5;
        send_word(8'h22, 2'd2, 1'b0, 3'b011, 1'b0, lat, rx, ok, ed);
        n_checks++; if (rx !== 8'hC5 || s_mosi !== 8'h22) begin n_fail++; $display("FAIL burst_w2_data: got rx=%h mosi=%h expected c5/22", rx, s_mosi); end
        n_checks++; if (lat !== 37 || ok !== 1'b1) begin n_fail++; $display("FAIL burst_w2_timing: got lat=%0d cs_ok=%b expected 37/1", lat, ok); end
        n_checks++; if (o_spi_cs !== 3'b111 || bus_if.o_TX_READY !== 1'b0) begin n_fail++; $display("FAIL burst_end: got cs=%b ready=%b expected 111/0", o_spi_cs, bus_if.o_TX_READY); end
        @(posedge i_clk); #1;
        n_checks++; if (bus_if.o_TX_READY !== 1'b0) begin n_fail++; $display("FAIL burst_gap2: got ready=%b expected 0", bus_if.o_TX_READY); end
        @(posedge i_clk); #1;
        n_checks++; if (bus_if.o_TX_READY !== 1'b1) begin n_fail++; $display("FAIL burst_gap_end: got ready=%b expected 1", bus_if.o_TX_READY); end
        n_checks++; if (n_rxde - nrx0 !== 2) begin n_fail++; $display("FAIL burst_rx_pulses: got %0d expected 2", n_rxde - nrx0); end
        s_active = 1'b0;
    endtask

    task automatic test_ignore();
        int lat; logic [7:0] rx; bit ok; int ed; int acc0;
        set_mode(1'b0, 1'b1);
        slave_arm(1'b0, 1'b1, 1'b0, 8'h3C);
        acc0 = n_acc;
        fork
            send_word(8'h96, 2'd1, 1'b1, 3'b101, 1'b1, lat, rx, ok, ed);
            begin
                repeat (12) @(posedge i_clk);
                #2 cpol_in = 1'b1; cpha_in = 1'b0; bus_if.i_CS_SEL = 2'd0;
            end
        join
        n_checks++; if (n_acc - acc0 !== 1) begin n_fail++; $display("FAIL ignore_accepts: got %0d expected 1", n_acc - acc0); end
        n_checks++; if (rx !== 8'h3C || s_mosi !== 8'h96 || ok !== 1'b1) begin n_fail++; $display("FAIL ignore_w1: got rx=%h mosi=%h cs_ok=%b expected 3c/96/1", rx, s_mosi, ok); end
        n_checks++; if (o_spi_clk !== 1'b0) begin n_fail++; $display("FAIL ignore_burst_sclk: got %b expected 0", o_spi_clk); end
        s_shift = 0; s_mosi = 8'h00; s_echo = 8'hE7;
        send_word(8'h4B, 2'd0, 1'b0, 3'b101, 1'b0, lat, rx, ok, ed);
        n_checks++; if (rx !== 8'hE7 || s_mosi !== 8'h4B) begin n_fail++; $display("FAIL ignore_w2_data: got rx=%h mosi=%h expected e7/4b", rx, s_mosi); end
        n_checks++; if (ok !== 1'b1 || ed !== 16 || lat !== 37) begin n_fail++; $display("FAIL ignore_w2_frame: got cs_ok=%b edges=%0d lat=%0d expected 1/16/37", ok, ed, lat); end
        n_checks++; if (n_acc - acc0 !== 2) begin n_fail++; $display("FAIL ignore_total_accepts: got %0d expected 2", n_acc - acc0); end
        s_active = 1'b0;
        set_mode(1'b0, 1'b0);
        repeat (3) @(posedge i_clk);
        #1;
    endtask

    task automatic test_cs_range();
        int lat; logic [7:0] rx; bit ok; int ed;
        set_mode(1'b0, 1'b0);
        slave_arm(1'b0, 1'b0, 1'b0, 8'h69);
        send_word(8'hF0, 2'd3, 1'b0, 3'b111, 1'b0, lat, rx, ok, ed);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL csrange_no_cs: got cs_ok=%b expected 1", ok); end
        n_checks++; if (rx !== 8'h69 || s_mosi !== 8'hF0) begin n_fail++; $display("FAIL csrange_data: got rx=%h mosi=%h expected 69/f0", rx, s_mosi); end
        s_active = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat; logic [7:0] rx; bit ok; int ed; int e0; int nrx0;
        set_mode(1'b0, 1'b0);
        slave_arm(1'b0, 1'b0, 1'b0, 8'h3C);
        for (int i = 0; i < 100; i++) begin
            if (bus_if.o_TX_READY === 1'b1) break;
            @(posedge i_clk); #1;
        end
        bus_if.i_TX_BYTE = 8'hA5; bus_if.i_CS_SEL = 2'd0; bus_if.i_HOLD_CS = 1'b0; bus_if.i_TX_DE = 1'b1;
        @(posedge i_clk);
        e0 = s_edges;
        #1 bus_if.i_TX_DE = 1'b0;
        for (int i = 0; i < 100 && (s_edges - e0) < 5; i++) begin
            @(posedge i_clk); #1;
        end
        n_checks++; if (s_edges - e0 !== 5) begin n_fail++; $display("FAIL rstmid_edge5: got %0d expected 5", s_edges - e0); end
        nrx0 = n_rxde;
        s_active = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++; if (o_spi_cs !== 3'b111 || o_spi_clk !== 1'b0) begin n_fail++; $display("FAIL rstmid_pins: got cs=%b sclk=%b expected 111/0", o_spi_cs, o_spi_clk); end
        n_checks++; if (bus_if.o_RX_BYTE !== 8'h00 || bus_if.o_RX_DE !== 1'b0) begin n_fail++; $display("FAIL rstmid_rx: got byte=%h de=%b expected 00/0", bus_if.o_RX_BYTE, bus_if.o_RX_DE); end
        repeat (3) @(posedge i_clk);
        #1 rst_n = 1'b1;
        repeat (50) @(posedge i_clk);
        #1;
        n_checks++; if (n_rxde - nrx0 !== 0) begin n_fail++; $display("FAIL rstmid_no_rx_de: got %0d expected 0", n_rxde - nrx0); end
        slave_arm(1'b0, 1'b0, 1'b0, 8'hC3);
        send_word(8'h5A, 2'd1, 1'b0, 3'b101, 1'b0, lat, rx, ok, ed);
        n_checks++; if (rx !== 8'hC3 || s_mosi !== 8'h5A) begin n_fail++; $display("FAIL rstmid_after: got rx=%h mosi=%h expected c3/5a", rx, s_mosi); end
        n_checks++; if (lat !== 37 || ok !== 1'b1) begin n_fail++; $display("FAIL rstmid_after_timing: got lat=%0d cs_ok=%b expected 37/1", lat, ok); end
        s_active = 1'b0;
    endtask

`ifdef SPI_MASTER_MCS_LSB_FIRST_EN
    task automatic test_lsb_first();
        int lat; logic [7:0] rx; bit ok; int ed;
        lsb_in = 1'b1;
        set_mode(1'b0, 1'b0);
        slave_arm(1'b0, 1'b0, 1'b1, 8'h80);
        send_word(8'h01, 2'd0, 1'b0, 3'b110, 1'b0, lat, rx, ok, ed);
        n_checks++; if (s_mosi !== 8'h01) begin n_fail++; $display("FAIL lsb_mosi: got %h expected 01", s_mosi); end
        n_checks++; if (rx !== 8'h80) begin n_fail++; $display("FAIL lsb_rx: got %h expected 80", rx); end
        s_active = 1'b0;
        lsb_in = 1'b0;
    endtask
`endif

    initial begin
        bus_if.i_TX_BYTE = 8'h00;
        bus_if.i_TX_DE   = 1'b0;
        bus_if.i_CS_SEL  = 2'd0;
        bus_if.i_HOLD_CS = 1'b0;
        test_reset();
        test_mode0();
        test_modes();
        test_burst();
        test_ignore();
        test_cs_range();
        test_reset_mid();
`ifdef SPI_MASTER_MCS_LSB_FIRST_EN
        test_lsb_first();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
